// File: rtl/lcd_pkg.sv
// Shared types, default timing and helpers for the HD44780 byte writer.
// The LCD_LONG_CMD_EN build uses is_long_cmd to pick the clear/home execution wait.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } lcd_wr_state_t;

    localparam int unsigned DEF_CYCLES_PER_US = 64;
    localparam int unsigned DEF_SETUP_US      = 1;
    localparam int unsigned DEF_PULSE_US      = 1;
    localparam int unsigned DEF_HOLD_US       = 1;
    localparam int unsigned DEF_EXEC_US       = 40;
    localparam int unsigned DEF_LONG_EXEC_US  = 1640;

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_us_tick.sv
// Microsecond prescaler: tick on every CYCLES_PER_US-th enabled cycle.
// tick_next flags the cycle just before tick so the caller can finish a state one cycle early.
module lcd_us_tick #(
    parameter int unsigned CYCLES_PER_US = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic tick_next
);
    localparam int unsigned W    = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
    localparam int unsigned LAST = CYCLES_PER_US - 1;
    localparam int unsigned PRE  = (CYCLES_PER_US > 1) ? CYCLES_PER_US - 2 : 0;

    logic [W-1:0] count;

    assign tick      = enable && (count == W'(LAST));
    assign tick_next = enable && ((CYCLES_PER_US == 1) || (count == W'(PRE)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == W'(LAST)) count <= '0;
            else                   count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_byte_writer.sv
// Writes one byte per request onto an HD44780 bus with setup/pulse/hold/exec timing.
// Define LCD_LONG_CMD_EN to give clear/home commands the LONG_EXEC_US wait.
module lcd_byte_writer
    import lcd_pkg::*;
#(
    parameter int unsigned CYCLES_PER_US = DEF_CYCLES_PER_US,
    parameter int unsigned SETUP_US      = DEF_SETUP_US,
    parameter int unsigned PULSE_US      = DEF_PULSE_US,
    parameter int unsigned HOLD_US       = DEF_HOLD_US,
    parameter int unsigned EXEC_US       = DEF_EXEC_US,
    parameter int unsigned LONG_EXEC_US  = DEF_LONG_EXEC_US
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       req_ready,
    output logic       cmd_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data
);
    localparam logic [10:0] SETUP_U = 11'(SETUP_US);
    localparam logic [10:0] PULSE_U = 11'(PULSE_US);
    localparam logic [10:0] HOLD_U  = 11'(HOLD_US);
    localparam logic [10:0] EXEC_U  = 11'(EXEC_US);

    lcd_wr_state_t state, next_state;
    logic [10:0]   units, target, exec_u;
    logic          tick, tick_next, entry, accept, last_unit;

    assign accept = (state == ST_IDLE) && req_valid;
    assign entry  = (next_state != state);
    assign lcd_rw = 1'b0;

`ifdef LCD_LONG_CMD_EN
    localparam logic [10:0] LONG_U = 11'(LONG_EXEC_US);
    logic long_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       long_q <= 1'b0;
        else if (accept) long_q <= is_long_cmd(req_rs, req_data);
    end

    assign exec_u = long_q ? LONG_U : EXEC_U;
`else
    assign exec_u = EXEC_U;
`endif

    lcd_us_tick #(
        .CYCLES_PER_US(CYCLES_PER_US)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clear    (entry),
        .enable   (state != ST_IDLE),
        .tick     (tick),
        .tick_next(tick_next)
    );

    always_comb begin
        target = 11'd1;
        case (state)
            ST_SETUP: target = SETUP_U;
            ST_PULSE: target = PULSE_U;
            ST_HOLD:  target = HOLD_U;
            ST_WAIT:  target = exec_u;
            default:  target = 11'd1;
        endcase
    end

    assign last_unit = (units == target - 11'd1);

    // WAIT leaves one cycle early; the single IDLE cycle that follows carries
    // cmd_done/req_ready, so accept-to-accept spacing stays a whole number of units.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (req_valid)              next_state = ST_SETUP;
            ST_SETUP: if (tick && last_unit)      next_state = ST_PULSE;
            ST_PULSE: if (tick && last_unit)      next_state = ST_HOLD;
            ST_HOLD:  if (tick && last_unit)      next_state = ST_WAIT;
            ST_WAIT:  if (tick_next && last_unit) next_state = ST_IDLE;
            default:                              next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            units <= '0;
        end else begin
            state <= next_state;
            if (entry)     units <= '0;
            else if (tick) units <= units + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ready <= 1'b1;
            cmd_done  <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= '0;
        end else begin
            req_ready <= (next_state == ST_IDLE);
            cmd_done  <= (state == ST_WAIT) && (next_state == ST_IDLE);
            lcd_e     <= (next_state == ST_PULSE);
            if (accept) begin
                lcd_rs   <= req_rs;
                lcd_data <= req_data;
            end
        end
    end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Self-checking bench for lcd_byte_writer: timing of E, cmd_done and ready against
// a cycle-arithmetic model of the bus protocol; honours LCD_LONG_CMD_EN when defined.
module tb_lcd_byte_writer;

    localparam int unsigned CPU   = 64;
    localparam int unsigned SU    = 1;
    localparam int unsigned PU    = 1;
    localparam int unsigned HU    = 1;
    localparam int unsigned EXU   = 40;
    localparam int unsigned LEXU  = 100;
    localparam int unsigned LIMIT = (SU + PU + HU + LEXU + 8) * CPU;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       req_ready, cmd_done, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_data;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned gcyc = 0;

    lcd_byte_writer #(
        .CYCLES_PER_US(CPU),
        .SETUP_US     (SU),
        .PULSE_US     (PU),
        .HOLD_US      (HU),
        .EXEC_US      (EXU),
        .LONG_EXEC_US (LEXU)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_rs   (req_rs),
        .req_data (req_data),
        .req_ready(req_ready),
        .cmd_done (cmd_done),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: execution wait in units chosen from the byte itself.
    function automatic int unsigned exec_units(input logic rs, input logic [7:0] d);
`ifdef LCD_LONG_CMD_EN
        if (rs == 1'b0 && d >= 8'h01 && d <= 8'h03) return LEXU;
`endif
        return EXU;
    endfunction

    // Issue one byte and measure its bus timing relative to the accept edge.
    task automatic write_byte(input logic rs, input logic [7:0] d, input bit noise,
                              output int unsigned erise_g);
        int unsigned cyc, rise, fall, done, pulses, w, exp_exec;
        bit data_bad, ready_bad;
        cyc = 0; rise = 0; fall = 0; done = 0; pulses = 0; w = 0;
        data_bad = 0; ready_bad = 0; erise_g = 0;
        exp_exec = exec_units(rs, d);
        while (req_ready !== 1'b1 && w < LIMIT) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        @(posedge clk);
        while (done == 0 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (lcd_data !== d || lcd_rs !== rs || lcd_rw !== 1'b0) data_bad = 1;
            if (lcd_e === 1'b1 && rise == 0) begin
                rise = cyc;
                erise_g = gcyc;
            end
            if (rise != 0 && fall == 0 && lcd_e === 1'b0) fall = cyc;
            if (cmd_done === 1'b1) begin
                pulses++;
                done = cyc;
            end
            if ((req_ready === 1'b1) != (cmd_done === 1'b1)) ready_bad = 1;
            if (noise) begin
                req_valid = 1'($urandom_range(0, 1));
                req_rs    = 1'($urandom_range(0, 1));
                req_data  = 8'($urandom);
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("e_rise_cycle", rise, 1 + SU * CPU);
        check("e_high_len", fall - rise, PU * CPU);
        check("done_cycle", done, (SU + PU + HU + exp_exec) * CPU);
        check("done_pulses", pulses, 1);
        check("data_stable", {31'd0, data_bad}, 32'd0);
        check("ready_only_at_done", {31'd0, ready_bad}, 32'd0);
    endtask

    initial begin
        int unsigned r1, r2, bad, pulses;
        logic rs;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        bad = 0; pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b1 || lcd_e !== 1'b0 || lcd_data !== 8'h00 ||
                lcd_rs !== 1'b0 || lcd_rw !== 1'b0) bad++;
            if (cmd_done !== 1'b0) pulses++;
        end
        check("reset_idle_outputs", bad, 0);
        check("reset_idle_no_done", pulses, 0);

        write_byte(1'b1, 8'h41, 1'b0, r1);
        write_byte(1'b0, 8'h01, 1'b0, r1);
        write_byte(1'b0, 8'h38, 1'b0, r1);
        write_byte(1'b0, 8'h03, 1'b0, r1);
        write_byte(1'b0, 8'h04, 1'b0, r1);
        write_byte(1'b1, 8'h01, 1'b0, r1);

        // Back-to-back with noisy req_valid/req_data while busy.
        write_byte(1'b1, 8'h48, 1'b1, r1);
        write_byte(1'b1, 8'h49, 1'b1, r2);
        check("b2b_e_spacing", r2 - r1, (SU + PU + HU + EXU) * CPU);

        for (int i = 0; i < 5; i++) begin
            rs = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            write_byte(rs, d, 1'($urandom_range(0, 1)), r1);
        end

        // Reset while E is high drops the byte.
        @(negedge clk);
        req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (79) @(negedge clk);
        check("pulse_e_high", {31'd0, lcd_e}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_e_low", {31'd0, lcd_e}, 32'd0);
        check("rst_data_zero", {24'd0, lcd_data}, 32'd0);
        check("rst_ready_high", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_done !== 1'b0) pulses++;
        end
        check("rst_no_done", pulses, 0);
        write_byte(1'b0, 8'h0C, 1'b1, r1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
